// File: rtl/quad_nco.sv
// Quadrature NCO: phase accumulator, programmable offset and a quarter-wave
// sine table folded into a full-cycle sin/cos pair, three-stage output pipe.
module quad_nco #(
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned LUT_AW   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter              LUT_FILE = "quarter_sine.mif"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic               cfg_sync,
    input  logic               phase_clr,
    output logic [DATA_W-1:0]  carrier_i,
    output logic [DATA_W-1:0]  carrier_q,
    output logic               out_valid,
    output logic               wrap
);

    localparam int unsigned DEPTH    = 1 << LUT_AW;
    localparam int unsigned PH_TOP_W = LUT_AW + 2;
    localparam int unsigned MAG_W    = DATA_W - 1;
    localparam real         PI       = 3.14159265358979323846;

    // The table must fit inside the phase word and the init file must be named.
    if (PHASE_W < PH_TOP_W || $bits(LUT_FILE) == 0) begin : g_param_check
        $error("quad_nco: PHASE_W too small for LUT_AW or LUT_FILE empty");
    end

    // Quarter-wave entry, sampled half a step in so the mirror is a plain ~k.
    function automatic logic [MAG_W-1:0] rom_entry(input int unsigned idx);
        real amp;
        real ang;
        amp = (2.0 ** MAG_W) - 1.0;
        ang = (real'(idx) + 0.5) * PI / (2.0 ** (LUT_AW + 1));
        return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [MAG_W-1:0] rom [DEPTH];

    // Table contents are closed-form constants; folded to a ROM by synthesis.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rom[LUT_AW'(i)] = rom_entry(i);
        end
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fcw;
    logic [PHASE_W-1:0] poff;
    logic [PHASE_W-1:0] sh_fcw;
    logic [PHASE_W-1:0] sh_poff;
    logic               pending;

    logic [PHASE_W:0]   sum_c;
    logic               carry_c;
    logic               hs_c;
    logic               apply_c;
    logic               pending_n_c;

    // Accumulator step, carry detection and config bookkeeping.
    always_comb begin
        sum_c       = {1'b0, acc} + {1'b0, fcw};
        carry_c     = en & ~phase_clr & sum_c[PHASE_W];
        hs_c        = cfg_valid & cfg_ready;
        apply_c     = pending & (carry_c | phase_clr);
        pending_n_c = pending;
        if (apply_c) begin
            pending_n_c = 1'b0;
        end else if (hs_c && cfg_sync) begin
            pending_n_c = 1'b1;
        end
    end

    // Phase accumulator and wrap strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= carry_c | phase_clr;
            if (phase_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= sum_c[PHASE_W-1:0];
            end
        end
    end

    // Tuning registers: immediate load, or shadowed until the next wrap/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw       <= '0;
            poff      <= '0;
            sh_fcw    <= '0;
            sh_poff   <= '0;
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            pending   <= pending_n_c;
            cfg_ready <= ~pending_n_c;
            if (apply_c) begin
                fcw  <= sh_fcw;
                poff <= sh_poff;
            end
            if (hs_c) begin
                if (cfg_sync) begin
                    sh_fcw  <= cfg_fcw;
                    sh_poff <= cfg_poff;
                end else begin
                    fcw  <= cfg_fcw;
                    poff <= cfg_poff;
                end
            end
        end
    end

    logic [PH_TOP_W-1:0] ph1;
    logic                v1;
    logic [1:0]          quad_c;
    logic [1:0]          quad_cos_c;
    logic [LUT_AW-1:0]   k_c;
    logic [LUT_AW-1:0]   addr_i_c;
    logic [LUT_AW-1:0]   addr_q_c;

    // Quadrant folding: odd quadrants mirror the index, upper half negates.
    always_comb begin
        quad_c     = ph1[PH_TOP_W-1 -: 2];
        k_c        = ph1[LUT_AW-1:0];
        quad_cos_c = quad_c + 2'd1;
        addr_i_c   = quad_c[0]     ? ~k_c : k_c;
        addr_q_c   = quad_cos_c[0] ? ~k_c : k_c;
    end

    logic [MAG_W-1:0] rom_i;
    logic [MAG_W-1:0] rom_q;
    logic             neg_i;
    logic             neg_q;
    logic             v2;

    // Three-stage sample pipe: phase, table read with sign, signed output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph1       <= '0;
            v1        <= 1'b0;
            rom_i     <= '0;
            rom_q     <= '0;
            neg_i     <= 1'b0;
            neg_q     <= 1'b0;
            v2        <= 1'b0;
            carrier_i <= '0;
            carrier_q <= '0;
            out_valid <= 1'b0;
        end else begin
            ph1       <= PH_TOP_W'((acc + poff) >> (PHASE_W - PH_TOP_W));
            v1        <= en;
            rom_i     <= rom[addr_i_c];
            rom_q     <= rom[addr_q_c];
            neg_i     <= quad_c[1];
            neg_q     <= quad_cos_c[1];
            v2        <= v1;
            carrier_i <= neg_i ? -{1'b0, rom_i} : {1'b0, rom_i};
            carrier_q <= neg_q ? -{1'b0, rom_q} : {1'b0, rom_q};
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_quad_nco.sv
// Randomised bench for quad_nco against a cycle-level behavioural model.
module tb_quad_nco;

    localparam int unsigned PW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam real         PI = 3.14159265358979323846;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_sync  = 1'b0;
    logic          phase_clr = 1'b0;
    logic [PW-1:0] cfg_fcw   = '0;
    logic [PW-1:0] cfg_poff  = '0;
    logic          cfg_ready;
    logic [DW-1:0] carrier_i;
    logic [DW-1:0] carrier_q;
    logic          out_valid;
    logic          wrap;

    quad_nco #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .LUT_FILE("quarter_sine.mif")) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_fcw   (cfg_fcw),
        .cfg_poff  (cfg_poff),
        .cfg_sync  (cfg_sync),
        .phase_clr (phase_clr),
        .carrier_i (carrier_i),
        .carrier_q (carrier_q),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: what the block should hold, in specification terms.
    logic [PW-1:0] m_acc, m_fcw, m_poff, m_sh_fcw, m_sh_poff;
    bit            m_pend, m_wrap;
    logic [PW-1:0] l_th [3];
    bit            l_v  [3];

    task automatic model_reset();
        m_acc = '0; m_fcw = '0; m_poff = '0; m_sh_fcw = '0; m_sh_poff = '0;
        m_pend = 1'b0; m_wrap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            l_th[i] = '0;
            l_v[i]  = 1'b0;
        end
    endtask

    function automatic longint rnd(input real x);
        if (x >= 0.0) return longint'($rtoi(x + 0.5));
        return -longint'($rtoi(-x + 0.5));
    endfunction

    // Ideal sin/cos at the centre of the table cell that the phase falls in.
    task automatic exp_sample(input logic [PW-1:0] th, output longint s, output longint c);
        real amp, ang;
        int unsigned j;
        j   = int'(th >> (PW - AW - 2));
        amp = (2.0 ** (DW - 1)) - 1.0;
        ang = (real'(j) + 0.5) * 2.0 * PI / (2.0 ** (AW + 2));
        s   = rnd(amp * $sin(ang));
        c   = rnd(amp * $cos(ang));
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic tick();
        logic [PW:0]   sum;
        logic [PW-1:0] th;
        bit            carry, hs;
        longint        es, ec;
        sum   = {1'b0, m_acc} + {1'b0, m_fcw};
        carry = en && !phase_clr && sum[PW];
        hs    = cfg_valid && !m_pend;
        th    = m_acc + m_poff;
        m_wrap = carry || phase_clr;
        if (phase_clr) m_acc = '0;
        else if (en)   m_acc = sum[PW-1:0];
        if (m_pend && (carry || phase_clr)) begin
            m_fcw  = m_sh_fcw;
            m_poff = m_sh_poff;
            m_pend = 1'b0;
        end
        if (hs) begin
            if (cfg_sync) begin
                m_sh_fcw  = cfg_fcw;
                m_sh_poff = cfg_poff;
                m_pend    = 1'b1;
            end else begin
                m_fcw  = cfg_fcw;
                m_poff = cfg_poff;
            end
        end
        l_v[2] = l_v[1]; l_th[2] = l_th[1];
        l_v[1] = l_v[0]; l_th[1] = l_th[0];
        l_v[0] = en;     l_th[0] = th;
        @(posedge clk);
        #1;
        check("wrap", longint'(wrap), longint'(m_wrap));
        check("cfg_ready", longint'(cfg_ready), longint'(!m_pend));
        check("out_valid", longint'(out_valid), longint'(l_v[2]));
        if (l_v[2]) begin
            exp_sample(l_th[2], es, ec);
            check("carrier_i", longint'($signed(carrier_i)), es);
            check("carrier_q", longint'($signed(carrier_q)), ec);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i"}, longint'(carrier_i), 0);
        check({tag, "_q"}, longint'(carrier_q), 0);
        check({tag, "_valid"}, longint'(out_valid), 0);
        check({tag, "_wrap"}, longint'(wrap), 0);
        check({tag, "_ready"}, longint'(cfg_ready), 1);
    endtask

    task automatic cfg(input logic [PW-1:0] f, input logic [PW-1:0] p, input logic s);
        cfg_fcw = f; cfg_poff = p; cfg_sync = s; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset held
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        ticks(3);

        // Quarter-cycle tone
        cfg(32'h4000_0000, 32'h0, 1'b0);
        en = 1'b1;
        ticks(12);

        // Half-cycle phase offset: both carriers negate
        cfg(32'h4000_0000, 32'h8000_0000, 1'b0);
        ticks(8);

        // Deferred retune to half rate; a second request while pending is refused
        cfg(32'h2000_0000, 32'h8000_0000, 1'b1);
        cfg_fcw = 32'h0800_0000; cfg_poff = 32'h1234_5678; cfg_valid = 1'b1;
        ticks(2);
        cfg_valid = 1'b0;
        ticks(16);

        // Clear mid-cycle applies the pending config at the same edge
        cfg(32'h4000_0000, 32'h0, 1'b1);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        ticks(3);
        check("clr_first_i", longint'($signed(carrier_i)), 25);
        check("clr_first_q", longint'($signed(carrier_q)), 32767);
        ticks(6);

        // Async reset mid-stream discards a pending config
        cfg(32'h1000_0000, 32'h4000_0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ticks(5);
        check("post_rst_i", longint'($signed(carrier_i)), 25);
        check("post_rst_q", longint'($signed(carrier_q)), 32767);
        ticks(4);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            en        = ($urandom_range(0, 7) != 0);
            phase_clr = ($urandom_range(0, 63) == 0);
            cfg_valid = ($urandom_range(0, 11) == 0);
            cfg_sync  = 1'($urandom_range(0, 1));
            cfg_fcw   = $urandom() >> $urandom_range(0, 6);
            if ($urandom_range(0, 31) == 0) cfg_fcw = '0;
            cfg_poff  = $urandom();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_nco.md
# quad_nco

Parametrised quadrature carrier generator: the phase-accumulator NCO that drives the I/Q mixers of the QAM modulator. It produces a sin/cos pair from a single quarter-wave ROM. It supports an arbitrary-width frequency tuning word, a programmable phase offset, and a valid/ready configuration port. Retuning is either immediate or deferred to the next phase wrap, which gives a phase-continuous, glitch-free change. Outputs are signed two's complement with an output-valid strobe.

## Interface
- PHASE_W, 32, accumulator / tuning-word / phase-offset width
- LUT_AW, 10, quarter-wave ROM address width (depth 2^LUT_AW; full cycle = 2^(LUT_AW+2) points)
- DATA_W, 16, signed output sample width
- LUT_FILE, "quarter_sine.mif", ROM init file
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- en  in  1  advance accumulator / launch one sample
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_fcw  in  PHASE_W  frequency tuning word (unsigned)
- cfg_poff  in  PHASE_W  phase offset (unsigned, 2^PHASE_W = 2π)
- cfg_sync  in  1  0 = apply immediately, 1 = apply at next wrap
- phase_clr  in  1  synchronous accumulator clear
- carrier_i  out  DATA_W  signed sin θ
- carrier_q  out  DATA_W  signed cos θ
- out_valid  out  1  carrier_i/q hold a new sample
- wrap  out  1  one-cycle pulse, accumulator wrapped or was cleared

## Operation
- Accumulator update, in priority order:
  - phase_clr: acc <= 0.
  - Otherwise, en: acc <= acc + fcw (mod 2^PHASE_W).
  - Otherwise: acc holds.
- Carry: the carry out of acc + fcw with en=1 and phase_clr=0.
- θ = acc + poff (mod 2^PHASE_W).
  - q = top 2 bits of θ.
  - k = next LUT_AW bits.
  - Lower bits are truncated.
- ROM contents: rom[k] = round((2^(DATA_W-1)-1)·sin((k+0.5)·π/2^(LUT_AW+1))). The half-step offset removes the need for an extra entry, and mirroring is ~k.
- sin lookup by quadrant q:
  - q=0: +rom[k]
  - q=1: +rom[~k]
  - q=2: −rom[k]
  - q=3: −rom[~k]
- cos is the same lookup using quadrant q+1 (mod 4).
- Negation never overflows, because |rom| ≤ 2^(DATA_W-1)−1.
- Config port:
  - cfg_ready = !pending.
  - Handshake (cfg_valid & cfg_ready) with cfg_sync=0: fcw/poff load at that same edge and pending stays 0.
  - Handshake with cfg_sync=1: values go to shadow regs and pending <= 1.
  - While pending, shadows load into fcw/poff at the first edge with a carry or with phase_clr=1, and pending clears at that edge.
  - A carry-producing increment at that edge uses the old fcw. New values take effect from the following cycle.
- Handshake coincident with a carry, sync mode: values are captured only. They apply at the next wrap, not this one.
- Handshake coincident with phase_clr, sync mode: values are captured only. They apply at the next wrap or clear.
- fcw=0 with a sync config pending: the config never applies until phase_clr.
- wrap: registered at the edge where a carry or phase_clr occurs.
- Pipeline always advances. out_valid is en delayed through the same stages. When out_valid=0, carrier_i/q still update but are don't-care.

## Timing
- Stages:
  - Edge k: ph1 <= acc + poff (pre-increment acc), v1 <= en.
  - Edge k+1: ROM read plus registered quadrant/sign, v2 <= v1.
  - Edge k+2: carrier_i/q registered, out_valid <= v2.
- Latency: 3 edges from en sampled to out_valid/sample.
- Sustained throughput: one sample per clock.
- poff change: seen by the sample launched at the next edge.
- Reset values:
  - acc, fcw, poff, shadows, pending, wrap, out_valid, carrier_i, carrier_q: 0.
  - cfg_ready: 1.
- Reset asserted mid-stream: all state clears immediately. A pending sync config is discarded.

## Test plan
- Reset: hold rst_n=0 and check all outputs 0 and cfg_ready=1. Release with en=0 and check out_valid stays 0.
- Quarter-cycle tone (defaults, cfg_fcw=2^30, poff=0, immediate, then en=1 steady):
  - First valid sample appears 3 edges after en.
  - carrier_i repeats 25, 32767, −25, −32767.
  - carrier_q repeats 32767, −25, −32767, 25.
  - wrap pulses every 4 cycles.
- Phase offset: cfg_poff=2^31 during the above tone. Both carriers negate, starting with the sample launched after the handshake.
- Sync retune:
  - From fcw=2^30, issue cfg_sync=1 with fcw=2^29.
  - cfg_ready drops.
  - The old rate continues until the wrap edge, then steps are 8 per cycle with no phase discontinuity.
  - cfg_ready returns to 1 after the apply edge.
  - A second cfg_valid while pending is not accepted.
- phase_clr mid-cycle: accumulator returns to 0, wrap pulses, and a pending sync config applies at that edge. The next launched sample gives I=25 and Q=32767.
- Async reset asserted mid-stream with a sync config pending: outputs zero immediately. After release, fcw=0 and the output is constant I=25 / Q=32767 with en=1.
